// File: rtl/bit_deserializer_pkg.sv
// bit_deserializer_pkg: shared types and helpers for the bit deserializer
package bit_deserializer_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/bit_deserializer_skid.sv
// word_skid_buffer: 2-entry FIFO of assembled words with registered full flag
module word_skid_buffer
  import bit_deserializer_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] dout
);
  buf_state_t state, state_nx;
  logic [WIDTH-1:0] head, tail;
  logic pop;
  assign valid = state != EMPTY;
  assign full  = state == FULL;
  assign dout  = head;
  assign pop   = valid && ready;
  always_comb begin
    state_nx = state == EMPTY ? (push ? ONE : EMPTY) :
               state == ONE   ? (push && !pop ? FULL : !push && pop ? EMPTY : ONE) :
                                (pop ? ONE : FULL);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nx;
      if (push && (state == EMPTY || pop)) head <= din;
      else if (pop && state == FULL) head <= tail;
      if (push && state == ONE && !pop) tail <= din;
    end
  end
endmodule

// File: rtl/bit_deserializer.sv
// bit_deserializer: assembles accepted serial bits into words with sof resync
module bit_deserializer
  import bit_deserializer_pkg::*;
#(
  parameter int WIDTH     = 13,
  parameter bit MSB_FIRST = 1'b1,
  parameter int DROPW     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bit_valid,
  input  logic             i_bit,
  input  logic             i_sof,
  output logic             o_bit_ready,
  output logic             o_word_valid,
  output logic [WIDTH-1:0] o_word,
  input  logic             i_word_ready,
  output logic [DROPW-1:0] o_drop_cnt,
  output logic             o_busy
);
  localparam int CW = cnt_width(WIDTH);
  logic [CW-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [DROPW-1:0] drop_nx;
  logic accept, last, push, full;
  // stale bits left by a resync are shifted out before the word completes
  always_comb begin
    accept  = i_bit_valid && !full;
    last    = cnt == CW'(WIDTH - 1);
    sr_nx   = !accept ? sr : MSB_FIRST ? {sr[WIDTH-2:0], i_bit} : {i_bit, sr[WIDTH-1:1]};
    push    = accept && !i_sof && last;
    cnt_nx  = !accept ? cnt : i_sof ? CW'(1) : last ? '0 : cnt + 1'b1;
    drop_nx = o_drop_cnt + DROPW'(accept && i_sof && cnt != '0 && o_drop_cnt != '1);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt        <= '0;
      sr         <= '0;
      o_drop_cnt <= '0;
    end else begin
      cnt        <= cnt_nx;
      sr         <= sr_nx;
      o_drop_cnt <= drop_nx;
    end
  end
  assign o_bit_ready = !full;
  assign o_busy      = cnt != '0;
  word_skid_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .din   (sr_nx),
    .ready (i_word_ready),
    .valid (o_word_valid),
    .full  (full),
    .dout  (o_word)
  );
endmodule

// File: tb/tb_bit_deserializer.sv
// tb_bit_deserializer: directed checks of MSB-first and LSB-first deserializers
module tb_bit_deserializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic a_v, a_b, a_s, a_rdy, a_wv, a_wr, a_busy;
  logic [12:0] a_w;
  logic [7:0] a_d;
  logic b_v, b_b, b_s, b_rdy, b_wv, b_wr, b_busy;
  logic [12:0] b_w;
  logic [7:0] b_d;
  logic [12:0] w;
  int tests = 0;
  int fails = 0;

  bit_deserializer #(.WIDTH(13), .MSB_FIRST(1'b1), .DROPW(8)) dut_msb (
    .i_clk(clk), .i_rst(rst), .i_bit_valid(a_v), .i_bit(a_b), .i_sof(a_s),
    .o_bit_ready(a_rdy), .o_word_valid(a_wv), .o_word(a_w), .i_word_ready(a_wr),
    .o_drop_cnt(a_d), .o_busy(a_busy)
  );
  bit_deserializer #(.WIDTH(13), .MSB_FIRST(1'b0), .DROPW(8)) dut_lsb (
    .i_clk(clk), .i_rst(rst), .i_bit_valid(b_v), .i_bit(b_b), .i_sof(b_s),
    .o_bit_ready(b_rdy), .o_word_valid(b_wv), .o_word(b_w), .i_word_ready(b_wr),
    .o_drop_cnt(b_d), .o_busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input bit sel, input logic bv, input logic sv);
    @(negedge clk);
    for (int n = 0; n < 100 && !(sel ? b_rdy : a_rdy); n++) @(negedge clk);
    chk("bit_ready_wait", sel ? b_rdy : a_rdy, 1'b1);
    if (sel) begin
      b_v = 1'b1; b_b = bv; b_s = sv;
    end else begin
      a_v = 1'b1; a_b = bv; a_s = sv;
    end
    @(posedge clk);
    #1;
    a_v = 1'b0; a_s = 1'b0; b_v = 1'b0; b_s = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [12:0] wd, input bit msb, input bit sof, input bit pulse);
    for (int i = 0; i < 13; i++) begin
      if (pulse && i == 12) b_wr = 1'b1;
      put(sel, msb ? wd[12-i] : wd[i], sof && i == 0);
      if (pulse && i == 12) b_wr = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_v = 1'b0; a_b = 1'b0; a_s = 1'b0; a_wr = 1'b1;
    b_v = 1'b0; b_b = 1'b0; b_s = 1'b0; b_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", a_wv, 1'b0);
    chk("rst_ready", a_rdy, 1'b1);
    chk("rst_word", a_w, 13'h0);
    chk("rst_drop", a_d, 8'h0);
    chk("rst_busy", a_busy, 1'b0);
    // single word, no stalls
    w = 13'h1345;
    for (int i = 0; i < 12; i++) put(1'b0, w[12-i], 1'b0);
    chk("t1_valid_early", a_wv, 1'b0);
    chk("t1_busy_mid", a_busy, 1'b1);
    put(1'b0, w[0], 1'b0);
    chk("t1_valid", a_wv, 1'b1);
    chk("t1_word", a_w, 13'h1345);
    chk("t1_busy_done", a_busy, 1'b0);
    @(posedge clk); #1;
    chk("t1_popped", a_wv, 1'b0);
    // backpressure fills the buffer
    a_wr = 1'b0;
    send(1'b0, 13'h0001, 1'b1, 1'b0, 1'b0);
    chk("t2_w1_valid", a_wv, 1'b1);
    chk("t2_w1_word", a_w, 13'h0001);
    chk("t2_w1_ready", a_rdy, 1'b1);
    send(1'b0, 13'h1FFF, 1'b1, 1'b0, 1'b0);
    chk("t2_full_ready", a_rdy, 1'b0);
    chk("t2_full_head", a_w, 13'h0001);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_hold_head", a_w, 13'h0001);
    chk("t2_hold_ready", a_rdy, 1'b0);
    chk("t2_hold_valid", a_wv, 1'b1);
    a_wr = 1'b1;
    @(posedge clk); #1;
    chk("t2_pop1_word", a_w, 13'h1FFF);
    chk("t2_pop1_ready", a_rdy, 1'b1);
    a_wr = 1'b0;
    send(1'b0, 13'h0AAA, 1'b1, 1'b0, 1'b0);
    chk("t2_w3_ready", a_rdy, 1'b0);
    chk("t2_w3_head", a_w, 13'h1FFF);
    a_wr = 1'b1;
    @(posedge clk); #1;
    chk("t2_pop2_word", a_w, 13'h0AAA);
    @(posedge clk); #1;
    chk("t2_empty", a_wv, 1'b0);
    // partial word truncated by sof
    put(1'b0, 1'b1, 1'b0);
    put(1'b0, 1'b0, 1'b0);
    put(1'b0, 1'b1, 1'b0);
    put(1'b0, 1'b0, 1'b0);
    put(1'b0, 1'b1, 1'b0);
    chk("t3_busy", a_busy, 1'b1);
    chk("t3_drop_before", a_d, 8'h0);
    send(1'b0, 13'h0F0F, 1'b1, 1'b1, 1'b0);
    chk("t3_drop", a_d, 8'h1);
    chk("t3_valid", a_wv, 1'b1);
    chk("t3_word", a_w, 13'h0F0F);
    @(posedge clk); #1;
    chk("t3_popped", a_wv, 1'b0);
    // drop counter saturation: first sof at cnt=0 drops nothing
    for (int k = 0; k < 100; k++) put(1'b0, 1'b1, 1'b1);
    chk("t4_drop_100", a_d, 8'd100);
    chk("t4_busy", a_busy, 1'b1);
    for (int k = 0; k < 200; k++) put(1'b0, 1'b0, 1'b1);
    chk("t4_drop_sat", a_d, 8'hFF);
    chk("t4_no_word", a_wv, 1'b0);
    // reset mid-word with one word buffered
    a_wr = 1'b0;
    for (int k = 0; k < 12; k++) put(1'b0, 1'b0, 1'b0);
    chk("t5_buffered", a_wv, 1'b1);
    chk("t5_buf_word", a_w, 13'h0);
    for (int k = 0; k < 7; k++) put(1'b0, 1'b1, 1'b0);
    chk("t5_busy", a_busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_valid", a_wv, 1'b0);
    chk("t5_busy0", a_busy, 1'b0);
    chk("t5_ready", a_rdy, 1'b1);
    chk("t5_drop", a_d, 8'h0);
    chk("t5_word0", a_w, 13'h0);
    a_wr = 1'b1;
    send(1'b0, 13'h0B6D, 1'b1, 1'b0, 1'b0);
    chk("t5_clean_valid", a_wv, 1'b1);
    chk("t5_clean_word", a_w, 13'h0B6D);
    chk("t5_clean_drop", a_d, 8'h0);
    // LSB-first instance
    b_wr = 1'b1;
    send(1'b1, 13'h1345, 1'b0, 1'b0, 1'b0);
    chk("t6_valid", b_wv, 1'b1);
    chk("t6_word", b_w, 13'h1345);
    @(posedge clk); #1;
    chk("t6_popped", b_wv, 1'b0);
    // ready pulses only on completing cycles: push and pop coincide in ONE
    b_wr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      w = 13'(k * 397 + 5);
      send(1'b1, w, 1'b0, 1'b0, 1'b1);
      chk("t6_pp_word", b_w, w);
      chk("t6_pp_valid", b_wv, 1'b1);
      chk("t6_pp_ready", b_rdy, 1'b1);
    end
    b_wr = 1'b1;
    @(posedge clk); #1;
    chk("t6_pp_drain", b_wv, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
